// File: rtl/sbn_dmem_resp.sv
// Single-port data memory responder with valid/ready request and response channels.
// Optional macro SBN_DMEM_CLEAR_EN adds a post-reset sweep that zeroes every word.
module sbn_dmem_resp #(
    parameter int FWIDTH = 8,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [FWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              halt,
    output logic [15:0]       wr_count
);

    localparam int DEPTH = 1 << FWIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RSP  = 2'd1
`ifdef SBN_DMEM_CLEAR_EN
        , ST_CLR = 2'd2
`endif
    } state_t;

`ifdef SBN_DMEM_CLEAR_EN
    localparam state_t RESET_STATE = ST_CLR;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    logic [DWIDTH-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic              rsp_we_q, rsp_we_d;
    logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              halt_q, halt_d;
    logic [15:0]       wr_count_q, wr_count_d;
    logic              mem_we;
    logic [FWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
`ifdef SBN_DMEM_CLEAR_EN
    logic [FWIDTH-1:0] clr_addr_q, clr_addr_d;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        rsp_we_d    = rsp_we_q;
        rsp_rdata_d = rsp_rdata_q;
        halt_d      = halt_q;
        wr_count_d  = wr_count_q;
        mem_we      = 1'b0;
        mem_addr    = req_addr;
        mem_wdata   = req_wdata;
`ifdef SBN_DMEM_CLEAR_EN
        clr_addr_d  = clr_addr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d  = ST_RSP;
                    rsp_we_d = req_we;
                    if (req_we) begin
                        mem_we      = 1'b1;
                        rsp_rdata_d = req_wdata;
                        if (&req_addr) halt_d = 1'b1;
                        if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
                    end else begin
                        rsp_rdata_d = mem[req_addr];
                    end
                end
            end
            ST_RSP: begin
                // Response registers are held; only the handshake moves the FSM.
                if (rsp_ready) state_d = ST_IDLE;
            end
`ifdef SBN_DMEM_CLEAR_EN
            ST_CLR: begin
                mem_we     = 1'b1;
                mem_addr   = clr_addr_q;
                mem_wdata  = '0;
                clr_addr_d = clr_addr_q + 1'b1;
                if (&clr_addr_q) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RSP);
    assign rsp_we    = rsp_we_q;
    assign rsp_rdata = rsp_rdata_q;
    assign halt      = halt_q;
    assign wr_count  = wr_count_q;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
            halt_q      <= 1'b0;
            wr_count_q  <= '0;
`ifdef SBN_DMEM_CLEAR_EN
            clr_addr_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rsp_we_q    <= rsp_we_d;
            rsp_rdata_q <= rsp_rdata_d;
            halt_q      <= halt_d;
            wr_count_q  <= wr_count_d;
`ifdef SBN_DMEM_CLEAR_EN
            clr_addr_q  <= clr_addr_d;
`endif
        end
    end

    // NOTE: the array has no reset; contents survive reset and only the clear sweep zeroes them.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) mem[mem_addr] <= mem_wdata;
    end

endmodule

// File: tb/tb_sbn_dmem_resp.sv
// Directed self-checking bench for sbn_dmem_resp; adapts its clear-sweep
// expectations when SBN_DMEM_CLEAR_EN is defined.
module tb_sbn_dmem_resp;

    localparam int FWIDTH = 8;
    localparam int DWIDTH = 32;
`ifdef SBN_DMEM_CLEAR_EN
    localparam int SWEEP_CYCLES = 256;
`else
    localparam int SWEEP_CYCLES = 0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [FWIDTH-1:0] req_addr = '0;
    logic [DWIDTH-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic              rsp_we;
    logic [DWIDTH-1:0] rsp_rdata;
    logic              halt;
    logic [15:0]       wr_count;

    int total = 0;
    int bad   = 0;

    sbn_dmem_resp #(.FWIDTH(FWIDTH), .DWIDTH(DWIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_we    (rsp_we),
        .rsp_rdata (rsp_rdata),
        .halt      (halt),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset over two edges, then count cycles until req_ready rises.
    task automatic do_reset(output int busy_cycles);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        busy_cycles = 0;
        while (!req_ready && busy_cycles < 1000) begin
            busy_cycles++;
            step();
        end
    endtask

    // Present a request, wait (bounded) for acceptance, return one cycle after the accept edge.
    task automatic send(input logic we, input logic [FWIDTH-1:0] addr, input logic [DWIDTH-1:0] data);
        int  waited;
        logic ok;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        ok = 1'b0;
        for (waited = 0; waited < 400; waited++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("req_accept_timeout", 64'(ok), 64'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int busy;

        // Reset state
        do_reset(busy);
        check("sweep_len", 64'(busy), 64'(SWEEP_CYCLES));
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_we", 64'(rsp_we), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_halt", 64'(halt), 64'd0);
        check("rst_wr_count", 64'(wr_count), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);

        // Write 0x10 = 5, response one cycle after acceptance
        send(1'b1, 8'h10, 32'h0000_0005);
        check("wr_rsp_valid", 64'(rsp_valid), 64'd1);
        check("wr_req_ready", 64'(req_ready), 64'd0);
        check("wr_rsp_we", 64'(rsp_we), 64'd1);
        check("wr_rsp_rdata", 64'(rsp_rdata), 64'h5);
        check("wr_count_1", 64'(wr_count), 64'd1);
        take_rsp();
        check("wr_rsp_drop", 64'(rsp_valid), 64'd0);
        check("wr_back_idle", 64'(req_ready), 64'd1);

        // Read back 0x10
        send(1'b0, 8'h10, 32'hDEAD_BEEF);
        check("rd_rsp_valid", 64'(rsp_valid), 64'd1);
        check("rd_rsp_we", 64'(rsp_we), 64'd0);
        check("rd_rsp_rdata", 64'(rsp_rdata), 64'h5);
        check("rd_wr_count", 64'(wr_count), 64'd1);

        // Stall: rsp_ready low for 5 cycles while a new write is offered
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'h11;
        req_wdata = 32'h0000_0099;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
            check("stall_rsp_rdata", 64'(rsp_rdata), 64'h5);
            check("stall_req_ready", 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        check("stall_no_accept", 64'(wr_count), 64'd1);
        take_rsp();

        // Idle with no request: state held
        for (int i = 0; i < 3; i++) step();
        check("idle_rdata_hold", 64'(rsp_rdata), 64'h5);
        check("idle_rsp_valid", 64'(rsp_valid), 64'd0);
        check("idle_wr_count", 64'(wr_count), 64'd1);

        // Write to all-ones address sets sticky halt
        send(1'b1, 8'hFF, 32'hFFFF_FFFE);
        check("halt_set", 64'(halt), 64'd1);
        check("halt_wr_rdata", 64'(rsp_rdata), 64'hFFFF_FFFE);
        check("halt_wr_count", 64'(wr_count), 64'd2);
        take_rsp();
        send(1'b0, 8'hFF, 32'h0);
        check("halt_rd_rdata", 64'(rsp_rdata), 64'hFFFF_FFFE);
        check("halt_sticky", 64'(halt), 64'd1);
        take_rsp();

        // Reset while in RSP after a write to 0x03
        send(1'b1, 8'h03, 32'h0000_00A5);
        check("abort_pre_valid", 64'(rsp_valid), 64'd1);
        check("abort_pre_count", 64'(wr_count), 64'd3);
        reset = 1'b1;
        step();
        check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        check("abort_halt_clr", 64'(halt), 64'd0);
        check("abort_count_clr", 64'(wr_count), 64'd0);
        check("abort_rdata_clr", 64'(rsp_rdata), 64'd0);
        reset = 1'b0;
        busy = 0;
        while (!req_ready && busy < 1000) begin
            busy++;
            step();
        end
        check("abort_sweep_len", 64'(busy), 64'(SWEEP_CYCLES));
        send(1'b0, 8'h03, 32'h0);
`ifdef SBN_DMEM_CLEAR_EN
        check("abort_rd_03", 64'(rsp_rdata), 64'h0);
`else
        check("abort_rd_03", 64'(rsp_rdata), 64'hA5);
`endif
        take_rsp();

`ifdef SBN_DMEM_CLEAR_EN
        // Preloaded word is wiped by the post-reset sweep
        send(1'b1, 8'h20, 32'h0000_1234);
        take_rsp();
        send(1'b0, 8'h20, 32'h0);
        check("clr_pre_rd", 64'(rsp_rdata), 64'h1234);
        take_rsp();
        do_reset(busy);
        check("clr_busy_len", 64'(busy), 64'd256);
        send(1'b0, 8'h20, 32'h0);
        check("clr_post_rd", 64'(rsp_rdata), 64'h0);
        take_rsp();
`endif

        // Saturation: preload the counter near the top instead of issuing 65k writes
        force dut.wr_count_q = 16'hFFFD;
        #1;
        release dut.wr_count_q;
        send(1'b1, 8'h40, 32'h1);
        check("sat_fffe", 64'(wr_count), 64'hFFFE);
        take_rsp();
        send(1'b1, 8'h41, 32'h2);
        check("sat_ffff", 64'(wr_count), 64'hFFFF);
        take_rsp();
        send(1'b1, 8'h42, 32'h3);
        check("sat_hold_1", 64'(wr_count), 64'hFFFF);
        take_rsp();
        send(1'b1, 8'h43, 32'h4);
        check("sat_hold_2", 64'(wr_count), 64'hFFFF);
        take_rsp();
        send(1'b0, 8'h41, 32'h0);
        check("sat_rd_41", 64'(rsp_rdata), 64'h2);
        take_rsp();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
